// File: rtl/mii_phy_init_ctrl_if.sv
// Pin-level bundle between the PHY bring-up controller and the MII PHY pads / status consumers.
// dbg_state mirrors the controller FSM so checkers can bind to it without hierarchical paths.
interface mii_phy_init_ctrl_if;
    logic       start;
    logic       phy_reset_n;
    logic       mdc;
    logic       mdio_i;
    logic       mdio_o;
    logic       mdio_t;
    logic       busy;
    logic       done;
    logic       link_up;
    logic       error;
    logic [2:0] dbg_state;

    modport master (
        input  start, mdio_i,
        output phy_reset_n, mdc, mdio_o, mdio_t, busy, done, link_up, error, dbg_state
    );

    modport slave (
        output start, mdio_i,
        input  phy_reset_n, mdc, mdio_o, mdio_t, busy, done, link_up, error, dbg_state
    );
endinterface

// File: rtl/mii_phy_init_ctrl.sv
// PHY bring-up sequencer: timed hard reset, fixed MDIO config writes, then periodic BMSR polling.
// start is a single-cycle request, honoured only while busy=0; no handshake or queuing.
module mii_phy_init_ctrl #(
    parameter int         CLK_DIV      = 50,
    parameter int         RESET_CYCLES = 1250000,
    parameter int         WAIT_CYCLES  = 625000,
    parameter int         POLL_CYCLES  = 12500000,
    parameter logic [4:0] PHY_ADDR     = 5'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    mii_phy_init_ctrl_if.master  bus
);
    localparam int MAX_A = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
    localparam int MAX_C = (MAX_A > POLL_CYCLES) ? MAX_A : POLL_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    localparam logic [2:0] S_RST_HOLD  = 3'd0;
    localparam logic [2:0] S_RST_WAIT  = 3'd1;
    localparam logic [2:0] S_CFG       = 3'd2;
    localparam logic [2:0] S_POLL_WAIT = 3'd3;
    localparam logic [2:0] S_POLL_RD   = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cfg_idx_q, cfg_idx_d;
    logic          active_q, active_d;
    logic          rd_frame_q, rd_frame_d;
    logic [5:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [63:0]   tx_q, tx_d;
    logic          mdc_q, mdc_d;
    logic          mdio_o_q, mdio_o_d;
    logic          mdio_t_q, mdio_t_d;
    logic          ta_ok_q, ta_ok_d;
    logic [2:0]    rd_q, rd_d;
    logic          link_q, link_d;
    logic          err_q, err_d;

    logic          frame_end;
    logic          load;
    logic          load_rd;
    logic [63:0]   load_word;
    logic          restart;

    function automatic logic [63:0] mk_frame(input logic rd, input logic [4:0] ra, input logic [15:0] data);
        return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), PHY_ADDR, ra,
                (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : data)};
    endfunction

    function automatic logic [63:0] cfg_frame(input logic [1:0] idx);
        case (idx)
            2'd0:    return mk_frame(1'b0, 5'd0, 16'h3100);
            2'd1:    return mk_frame(1'b0, 5'd4, 16'h01E1);
            default: return mk_frame(1'b0, 5'd0, 16'h3300);
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cfg_idx_d  = cfg_idx_q;
        active_d   = active_q;
        rd_frame_d = rd_frame_q;
        bit_d      = bit_q;
        div_d      = div_q;
        tx_d       = tx_q;
        mdc_d      = mdc_q;
        mdio_o_d   = mdio_o_q;
        mdio_t_d   = mdio_t_q;
        ta_ok_d    = ta_ok_q;
        rd_d       = rd_q;
        link_d     = link_q;
        err_d      = err_q;
        frame_end  = 1'b0;
        load       = 1'b0;
        load_rd    = 1'b0;
        load_word  = '0;
        restart    = 1'b0;

        // Bit engine: mdc low for the first CLK_DIV cycles of a bit, high for the rest.
        if (active_q) begin
            div_d = div_q + 1'b1;
            if (div_q == DW'(CLK_DIV - 1)) begin
                mdc_d = 1'b1;
                if (rd_frame_q) begin
                    if (bit_q == 6'd47) ta_ok_d = ~bus.mdio_i;
                    if (bit_q >= 6'd48) rd_d = {rd_q[1:0], bus.mdio_i};
                end
            end
            if (rd_frame_q && bit_q == 6'd63 && div_q == DW'(CLK_DIV)) begin
                if (ta_ok_q) link_d = rd_q[2];
                else         err_d  = 1'b1;
            end
            if (div_q == DW'(2 * CLK_DIV - 1)) begin
                div_d = '0;
                mdc_d = 1'b0;
                if (bit_q == 6'd63) begin
                    frame_end = 1'b1;
                    active_d  = 1'b0;
                    mdio_o_d  = 1'b1;
                    mdio_t_d  = 1'b1;
                end else begin
                    bit_d    = bit_q + 1'b1;
                    tx_d     = tx_q << 1;
                    mdio_o_d = tx_q[62];
                    mdio_t_d = rd_frame_q && (bit_q >= 6'd45);
                end
            end
        end

        case (state_q)
            S_RST_HOLD: begin
                if (cnt_q == CW'(RESET_CYCLES - 1)) begin
                    state_d = S_RST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
                    state_d   = S_CFG;
                    cnt_d     = '0;
                    cfg_idx_d = 2'd0;
                    load      = 1'b1;
                    load_word = cfg_frame(2'd0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CFG: begin
                if (frame_end) begin
                    if (cfg_idx_q == 2'd2) begin
                        state_d = S_POLL_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cfg_idx_d = cfg_idx_q + 1'b1;
                        load      = 1'b1;
                        load_word = cfg_frame(cfg_idx_q + 2'd1);
                    end
                end
            end
            S_POLL_WAIT: begin
                if (bus.start) begin
                    restart = 1'b1;
                end else if (cnt_q == CW'(POLL_CYCLES - 1)) begin
                    state_d   = S_POLL_RD;
                    cnt_d     = '0;
                    load      = 1'b1;
                    load_rd   = 1'b1;
                    load_word = mk_frame(1'b1, 5'd1, 16'hFFFF);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_POLL_RD: begin
                if (bus.start) begin
                    restart = 1'b1;
                end else if (frame_end) begin
                    state_d = S_POLL_WAIT;
                    cnt_d   = '0;
                end
            end
            default: restart = 1'b1;
        endcase

        if (load) begin
            active_d   = 1'b1;
            rd_frame_d = load_rd;
            bit_d      = '0;
            div_d      = '0;
            mdc_d      = 1'b0;
            tx_d       = load_word;
            mdio_o_d   = load_word[63];
            mdio_t_d   = 1'b0;
            ta_ok_d    = 1'b0;
        end

        // An accepted start abandons any poll frame and reruns the whole bring-up.
        if (restart) begin
            state_d  = S_RST_HOLD;
            cnt_d    = '0;
            active_d = 1'b0;
            mdc_d    = 1'b0;
            mdio_o_d = 1'b1;
            mdio_t_d = 1'b1;
            link_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RST_HOLD;
            cnt_q      <= '0;
            cfg_idx_q  <= '0;
            active_q   <= 1'b0;
            rd_frame_q <= 1'b0;
            bit_q      <= '0;
            div_q      <= '0;
            tx_q       <= '0;
            mdc_q      <= 1'b0;
            mdio_o_q   <= 1'b1;
            mdio_t_q   <= 1'b1;
            ta_ok_q    <= 1'b0;
            rd_q       <= '0;
            link_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cfg_idx_q  <= cfg_idx_d;
            active_q   <= active_d;
            rd_frame_q <= rd_frame_d;
            bit_q      <= bit_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            mdc_q      <= mdc_d;
            mdio_o_q   <= mdio_o_d;
            mdio_t_q   <= mdio_t_d;
            ta_ok_q    <= ta_ok_d;
            rd_q       <= rd_d;
            link_q     <= link_d;
            err_q      <= err_d;
        end
    end

    assign bus.phy_reset_n = (state_q != S_RST_HOLD);
    assign bus.busy        = (state_q == S_RST_HOLD) || (state_q == S_RST_WAIT) || (state_q == S_CFG);
    assign bus.done        = (state_q == S_POLL_WAIT) || (state_q == S_POLL_RD);
    assign bus.mdc         = mdc_q;
    assign bus.mdio_o      = mdio_o_q;
    assign bus.mdio_t      = mdio_t_q;
    assign bus.link_up     = link_q;
    assign bus.error       = err_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_mii_phy_init_ctrl.sv
// Directed bench for mii_phy_init_ctrl: bring-up timing, MDIO frame contents, BMSR polling,
// TA error handling, start/rst interactions. Frames are checked against an expected queue.
module tb_mii_phy_init_ctrl;
    logic clk = 1'b0;
    logic rst;

    mii_phy_init_ctrl_if bus();

    mii_phy_init_ctrl #(
        .CLK_DIV      (2),
        .RESET_CYCLES (10),
        .WAIT_CYCLES  (5),
        .POLL_CYCLES  (300),
        .PHY_ADDR     (5'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    logic [63:0] exp_t_q[$];

    logic [15:0] bmsr       = 16'h0000;
    logic        float_mode = 1'b0;
    int          bitcnt     = 0;
    int          frames_seen = 0;
    logic [63:0] cap_o = '0;
    logic [63:0] cap_t = '0;
    logic        prev_mdc = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] frame(input logic rd, input logic [4:0] ra, input logic [15:0] data);
        return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), 5'd1, ra,
                (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : data)};
    endfunction

    function automatic logic phy_bit(input int n, input logic [15:0] d);
        if (n == 47) return 1'b0;
        if (n >= 48 && n <= 63) return d[63 - n];
        return 1'b1;
    endfunction

    // PHY side: answers reads from the monitor's bit position; loops the pad back when driven.
    assign bus.mdio_i = bus.mdio_t ? (float_mode ? 1'b1 : phy_bit(bitcnt, bmsr)) : bus.mdio_o;

    function automatic logic [7:0] outs();
        return {bus.phy_reset_n, bus.mdc, bus.mdio_o, bus.mdio_t,
                bus.busy, bus.done, bus.link_up, bus.error};
    endfunction

    task automatic push_cfg();
        exp_q.push_back(frame(1'b0, 5'd0, 16'h3100)); exp_t_q.push_back(64'h0);
        exp_q.push_back(frame(1'b0, 5'd4, 16'h01E1)); exp_t_q.push_back(64'h0);
        exp_q.push_back(frame(1'b0, 5'd0, 16'h3300)); exp_t_q.push_back(64'h0);
    endtask

    task automatic push_rd();
        exp_q.push_back(frame(1'b1, 5'd1, 16'hFFFF));
        exp_t_q.push_back(64'h0000_0000_0003_FFFF);
    endtask

    // Frame monitor: captures one bit per mdc rise; released bits read as 1.
    always @(negedge clk) begin
        logic [63:0] e;
        logic [63:0] et;
        if (rst) begin
            bitcnt = 0;
        end else if (bus.mdc && !prev_mdc) begin
            cap_o  = {cap_o[62:0], bus.mdio_o};
            cap_t  = {cap_t[62:0], bus.mdio_t};
            bitcnt = bitcnt + 1;
            if (bitcnt == 64) begin
                bitcnt = 0;
                frames_seen = frames_seen + 1;
                check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    et = exp_t_q.pop_front();
                    check("frame_bits", cap_o | cap_t, e);
                    check("frame_tristate", cap_t, et);
                end
            end
        end
        prev_mdc = bus.mdc;
    end

    task automatic measure_bringup(input string tag);
        int n;
        n = 0;
        while (bus.phy_reset_n !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_reset_low_cycles"}, 64'(n), 64'd10);
        n = 0;
        while (bus.mdc !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_first_mdc_rise"}, 64'(n), 64'd7);
    endtask

    task automatic wait_done(input string tag);
        int   n;
        logic saw_reset;
        n = 0;
        saw_reset = 1'b0;
        while (bus.done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.phy_reset_n !== 1'b1) saw_reset = 1'b1;
        end
        check({tag, "_done_busy"}, {62'd0, bus.done, bus.busy}, 64'b10);
        check({tag, "_idle_pins"}, {61'd0, bus.mdc, bus.mdio_t, bus.mdio_o}, 64'b011);
        check({tag, "_no_reset_in_cfg"}, 64'(saw_reset), 64'd0);
        check({tag, "_cfg_frames_seen"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_seen < target && n < 1500) begin
            @(negedge clk);
            n++;
        end
        check("poll_frame_arrived", 64'(frames_seen >= target), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        int f;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 64'(outs()), 64'b0011_1000);

        // Bring-up with a start pulse dropped in the middle of CFG.
        push_cfg();
        rst = 1'b0;
        measure_bringup("first");
        repeat (300) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_ignored_in_cfg", {62'd0, bus.busy, bus.phy_reset_n}, 64'b11);
        wait_done("first");

        // Polling: first poll POLL_CYCLES after done, then BMSR drives link_up.
        f = frames_seen;
        bmsr = 16'h782D;
        push_rd();
        n = 0;
        while (bus.mdc !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("poll_latency", 64'(n), 64'd302);
        check("link_before_poll", 64'(bus.link_up), 64'd0);
        wait_frames(f + 1);
        check("link_up_782d", 64'(bus.link_up), 64'd1);

        bmsr = 16'h7809;
        push_rd();
        wait_frames(f + 2);
        check("link_down_7809", 64'(bus.link_up), 64'd0);

        bmsr = 16'h782D;
        push_rd();
        wait_frames(f + 3);
        check("link_up_again", 64'(bus.link_up), 64'd1);

        float_mode = 1'b1;
        push_rd();
        wait_frames(f + 4);
        check("ta_error_link_held", {62'd0, bus.error, bus.link_up}, 64'b11);
        float_mode = 1'b0;

        // Accepted start: clears error/link and reruns from RST_HOLD.
        push_cfg();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_restart_state", 64'(outs()), 64'b0011_1000);
        measure_bringup("restart");

        // rst in the middle of the first config frame.
        repeat (100) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_t_q.delete();
        @(negedge clk);
        check("rst_midframe_pins",
              {60'd0, bus.mdio_t, bus.mdc, bus.phy_reset_n, bus.busy}, 64'b1001);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // rst and start together: reset wins, one clean bring-up follows.
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_and_start_state", 64'(outs()), 64'b0011_1000);
        push_cfg();
        f = frames_seen;
        measure_bringup("rst_start");
        wait_done("rst_start");
        check("rst_start_frame_count", 64'(frames_seen - f), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
